mem_bus_arbiter: RTL and testbench

- Shares the single synchronous main-memory port between the CPU datapath (requester 0) and the debug monitor (requester 1).
- Serialises accesses with a small FSM: one transaction at a time, fixed 2-cycle request-to-ack latency.
- Default priority goes to the CPU. A starvation counter guarantees the monitor a grant, and a monitor hold input can freeze CPU accesses while the monitor inspects or patches memory.

---
 rtl/mem_bus_arbiter.sv | 164 ++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Arbiter sharing one synchronous memory port between the CPU (requester 0) and the debug monitor (requester 1).
// Optional CPU write protection of the top address range is enabled by defining MEM_ARB_WPROT_EN.
module mem_bus_arbiter #(
    parameter int unsigned ADDR_W       = 8,
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned MON_MAX_WAIT = 4
`ifdef MEM_ARB_WPROT_EN
    ,
    parameter logic [ADDR_W-1:0] WPROT_BASE = ADDR_W'(8'hF0)
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
`ifdef MEM_ARB_WPROT_EN
    output logic              cpu_wperr,
`endif
    input  logic              mon_req,
    input  logic              mon_we,
    input  logic [ADDR_W-1:0] mon_addr,
    input  logic [DATA_W-1:0] mon_wdata,
    output logic              mon_ack,
    output logic [DATA_W-1:0] mon_rdata,
    input  logic              mon_hold,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned CNT_W = 4;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ACC_CPU = 3'd1,
        ACC_MON = 3'd2,
        RSP_CPU = 3'd3,
        RSP_MON = 3'd4
    } state_t;

    state_t             state, state_d;
    logic [CNT_W-1:0]   starve_cnt, cnt_d;
    logic [ADDR_W-1:0]  addr_d;
    logic [DATA_W-1:0]  wdata_d;
    logic               we_d;
    logic               cpu_ack_d;
    logic               mon_ack_d;
    logic               cpu_eff;
    logic               starve_full;
    logic               cpu_we_eff;
`ifdef MEM_ARB_WPROT_EN
    logic               wp_hit, wp_d, wperr_d;
`endif

    assign cpu_eff     = cpu_req & ~mon_hold;
    assign starve_full = (starve_cnt == CNT_W'(MON_MAX_WAIT));

`ifdef MEM_ARB_WPROT_EN
    assign cpu_we_eff  = cpu_we & (cpu_addr < WPROT_BASE);
`else
    assign cpu_we_eff  = cpu_we;
`endif

    // Memory data is only valid in the response cycle, so read data is steered straight through
    assign cpu_rdata = (state == RSP_CPU) ? mem_rdata : '0;
    assign mon_rdata = (state == RSP_MON) ? mem_rdata : '0;

    // Next-state, arbitration and memory-port values
    always_comb begin
        state_d   = state;
        cnt_d     = starve_cnt;
        addr_d    = mem_addr;
        wdata_d   = mem_wdata;
        we_d      = 1'b0;
        cpu_ack_d = 1'b0;
        mon_ack_d = 1'b0;
`ifdef MEM_ARB_WPROT_EN
        wp_d      = wp_hit;
        wperr_d   = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (!mon_req) begin
                    cnt_d = '0;
                end
                if (mon_req && (!cpu_eff || starve_full)) begin
                    state_d = ACC_MON;
                    addr_d  = mon_addr;
                    wdata_d = mon_wdata;
                    we_d    = mon_we;
                    cnt_d   = '0;
                end else if (cpu_eff) begin
                    state_d = ACC_CPU;
                    addr_d  = cpu_addr;
                    wdata_d = cpu_wdata;
                    we_d    = cpu_we_eff;
                    // CPU only wins against a pending monitor while the counter is below its limit
                    cnt_d   = mon_req ? starve_cnt + CNT_W'(1) : '0;
`ifdef MEM_ARB_WPROT_EN
                    wp_d    = cpu_we & ~cpu_we_eff;
`endif
                end
            end
            ACC_CPU: begin
                state_d   = RSP_CPU;
                cpu_ack_d = 1'b1;
`ifdef MEM_ARB_WPROT_EN
                wperr_d   = wp_hit;
`endif
            end
            ACC_MON: begin
                state_d   = RSP_MON;
                mon_ack_d = 1'b1;
            end
            RSP_CPU, RSP_MON: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Registered memory port, acks and starvation counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_we     <= 1'b0;
            cpu_ack    <= 1'b0;
            mon_ack    <= 1'b0;
`ifdef MEM_ARB_WPROT_EN
            wp_hit     <= 1'b0;
            cpu_wperr  <= 1'b0;
`endif
        end else begin
            starve_cnt <= cnt_d;
            mem_addr   <= addr_d;
            mem_wdata  <= wdata_d;
            mem_we     <= we_d;
            cpu_ack    <= cpu_ack_d;
            mon_ack    <= mon_ack_d;
`ifdef MEM_ARB_WPROT_EN
            wp_hit     <= wp_d;
            cpu_wperr  <= wperr_d;
`endif
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed self-checking bench for mem_bus_arbiter with a synchronous memory model.
// Define MEM_ARB_WPROT_EN to also exercise the write-protect feature.
module tb_mem_bus_arbiter;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DATA_W = 8;

    logic              clk;
    logic              reset;
    logic              cpu_req, cpu_we, cpu_ack;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata, cpu_rdata;
    logic              mon_req, mon_we, mon_ack, mon_hold;
    logic [ADDR_W-1:0] mon_addr;
    logic [DATA_W-1:0] mon_wdata, mon_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;
    logic              mem_we;
`ifdef MEM_ARB_WPROT_EN
    logic              cpu_wperr;
`endif

    logic [DATA_W-1:0] mem [256];

    int checks = 0;
    int errors = 0;

    mem_bus_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_ack   (cpu_ack),
        .cpu_rdata (cpu_rdata),
`ifdef MEM_ARB_WPROT_EN
        .cpu_wperr (cpu_wperr),
`endif
        .mon_req   (mon_req),
        .mon_we    (mon_we),
        .mon_addr  (mon_addr),
        .mon_wdata (mon_wdata),
        .mon_ack   (mon_ack),
        .mon_rdata (mon_rdata),
        .mon_hold  (mon_hold),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous single-port memory: read data one cycle after address
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int  n_cpu, n_mon, n_both, seen;
        logic grants [6];
        logic exp_grants [6];
        exp_grants = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

        for (int i = 0; i < 256; i++) mem[i] = '0;
        mem[8'h10] = 8'h5A;
        mem_rdata  = '0;
        reset = 1'b1;
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        mon_req = 0; mon_we = 0; mon_addr = '0; mon_wdata = '0; mon_hold = 0;
        tick(); tick();

        // Reset state
        chk("rst_cpu_ack", 32'(cpu_ack), 32'h0);
        chk("rst_mon_ack", 32'(mon_ack), 32'h0);
        chk("rst_mem_addr", 32'(mem_addr), 32'h0);
        chk("rst_mem_wdata", 32'(mem_wdata), 32'h0);
        chk("rst_mem_we", 32'(mem_we), 32'h0);
        chk("rst_cpu_rdata", 32'(cpu_rdata), 32'h0);
`ifdef MEM_ARB_WPROT_EN
        chk("rst_cpu_wperr", 32'(cpu_wperr), 32'h0);
`endif
        reset = 1'b0;
        tick();

        // CPU read of 0x10
        cpu_req = 1; cpu_we = 0; cpu_addr = 8'h10;
        tick();
        chk("rd_acc_addr", 32'(mem_addr), 32'h10);
        chk("rd_acc_we", 32'(mem_we), 32'h0);
        chk("rd_acc_ack", 32'(cpu_ack), 32'h0);
        tick();
        chk("rd_rsp_ack", 32'(cpu_ack), 32'h1);
        chk("rd_rsp_data", 32'(cpu_rdata), 32'h5A);
        chk("rd_rsp_we", 32'(mem_we), 32'h0);
        chk("rd_rsp_monack", 32'(mon_ack), 32'h0);
        cpu_req = 0;
        tick();
        chk("rd_idle_ack", 32'(cpu_ack), 32'h0);

        // Monitor write 0xC3 to 0x20, then CPU read-back
        mon_req = 1; mon_we = 1; mon_addr = 8'h20; mon_wdata = 8'hC3;
        tick();
        chk("mw_acc_we", 32'(mem_we), 32'h1);
        chk("mw_acc_addr", 32'(mem_addr), 32'h20);
        chk("mw_acc_wdata", 32'(mem_wdata), 32'hC3);
        chk("mw_acc_ack", 32'(mon_ack), 32'h0);
        mon_req = 0;
        tick();
        chk("mw_rsp_we", 32'(mem_we), 32'h0);
        chk("mw_rsp_ack", 32'(mon_ack), 32'h1);
        chk("mw_rsp_cpuack", 32'(cpu_ack), 32'h0);
        tick();
        chk("mw_idle_ack", 32'(mon_ack), 32'h0);
        cpu_req = 1; cpu_we = 0; cpu_addr = 8'h20;
        tick(); tick();
        chk("rb_ack", 32'(cpu_ack), 32'h1);
        chk("rb_data", 32'(cpu_rdata), 32'hC3);
        cpu_req = 0;
        tick();

        // Both requesting continuously: starvation limit forces the monitor in
        cpu_req = 1; cpu_we = 0; cpu_addr = 8'h10;
        mon_req = 1; mon_we = 0; mon_addr = 8'h30;
        n_cpu = 0; n_both = 0;
        for (int c = 0; c < 18; c++) begin
            tick();
            if (cpu_ack && mon_ack) n_both++;
            if (cpu_ack || mon_ack) begin
                if (n_cpu < 6) grants[n_cpu] = mon_ack;
                n_cpu++;
            end
        end
        cpu_req = 0; mon_req = 0;
        chk("arb_count", 32'(n_cpu), 32'd6);
        chk("arb_double_ack", 32'(n_both), 32'd0);
        for (int g = 0; g < 6; g++) chk($sformatf("arb_grant%0d", g), 32'(grants[g]), 32'(exp_grants[g]));
        tick(); tick();
        chk("arb_quiet", 32'(cpu_ack | mon_ack), 32'h0);

        // Monitor hold blocks the CPU; CPU served shortly after release
        mon_hold = 1; cpu_req = 1; cpu_addr = 8'h10; mon_req = 1; mon_we = 0; mon_addr = 8'h20;
        tick();
        mon_req = 0;
        n_cpu = 0; n_mon = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (cpu_ack) n_cpu++;
            if (mon_ack) n_mon++;
        end
        chk("hold_cpu_acks", 32'(n_cpu), 32'd0);
        chk("hold_mon_acks", 32'(n_mon), 32'd1);
        mon_hold = 0;
        seen = 0;
        for (int c = 0; c < 3 && seen == 0; c++) begin
            tick();
            if (cpu_ack) begin
                seen = 1;
                chk("hold_rel_data", 32'(cpu_rdata), 32'h5A);
            end
        end
        chk("hold_rel_served", 32'(seen), 32'd1);
        cpu_req = 0;
        tick();

        // Reset in ACC_CPU aborts the write without ack
        cpu_req = 1; cpu_we = 1; cpu_addr = 8'h44; cpu_wdata = 8'h77;
        tick();
        chk("abort_acc_we", 32'(mem_we), 32'h1);
        cpu_req = 0; cpu_we = 0;
        reset = 1;
        #1;
        chk("abort_we", 32'(mem_we), 32'h0);
        chk("abort_addr", 32'(mem_addr), 32'h0);
        chk("abort_wdata", 32'(mem_wdata), 32'h0);
        chk("abort_ack", 32'(cpu_ack), 32'h0);
        tick();
        chk("abort_ack2", 32'(cpu_ack), 32'h0);
        chk("abort_mem", 32'(mem[8'h44]), 32'h0);
        reset = 0;
        tick();
        cpu_req = 1; cpu_addr = 8'h10;
        tick();
        chk("rereq_acc_ack", 32'(cpu_ack), 32'h0);
        tick();
        chk("rereq_ack", 32'(cpu_ack), 32'h1);
        chk("rereq_data", 32'(cpu_rdata), 32'h5A);
        cpu_req = 0;
        tick();

`ifdef MEM_ARB_WPROT_EN
        // Protected CPU write is sequenced but never reaches memory
        cpu_req = 1; cpu_we = 1; cpu_addr = 8'hF5; cpu_wdata = 8'h11;
        tick();
        chk("wp_f5_we", 32'(mem_we), 32'h0);
        cpu_req = 0; cpu_we = 0;
        tick();
        chk("wp_f5_ack", 32'(cpu_ack), 32'h1);
        chk("wp_f5_err", 32'(cpu_wperr), 32'h1);
        tick();
        chk("wp_f5_err_clr", 32'(cpu_wperr), 32'h0);
        chk("wp_f5_mem", 32'(mem[8'hF5]), 32'h0);
        cpu_req = 1; cpu_we = 1; cpu_addr = 8'hEF; cpu_wdata = 8'h22;
        tick();
        chk("wp_ef_we", 32'(mem_we), 32'h1);
        cpu_req = 0; cpu_we = 0;
        tick();
        chk("wp_ef_ack", 32'(cpu_ack), 32'h1);
        chk("wp_ef_err", 32'(cpu_wperr), 32'h0);
        tick();
        mon_req = 1; mon_we = 1; mon_addr = 8'hF5; mon_wdata = 8'h33;
        tick();
        chk("wp_mon_we", 32'(mem_we), 32'h1);
        mon_req = 0; mon_we = 0;
        tick();
        chk("wp_mon_ack", 32'(mon_ack), 32'h1);
        chk("wp_mon_err", 32'(cpu_wperr), 32'h0);
        tick();
        chk("wp_mon_mem", 32'(mem[8'hF5]), 32'h33);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
